fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width; matches FIFO DSIZE.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, rclk cycles per serial bit; legal range 2..65535.
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-004 rclk  input  1  clock; one clock, all logic on rising edge.
REQ-005 rrst  input  1  reset, asynchronous, active-high.
REQ-006 rdata  input  DSIZE  FIFO read data; valid whenever rempty is low.
REQ-007 rempty  input  1  FIFO empty flag from the read side.
REQ-008 rinc  output  1  FIFO pop strobe; one-cycle pulse per word.
REQ-009 txd  output  1  serial line, idle high, LSB first.
REQ-010 busy  output  1  high from the pop cycle through the last stop-bit cycle.

Function
REQ-011 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-012 In IDLE with rempty low, rinc SHALL be high combinationally for that cycle, rdata SHALL be latched into the shift register, and the next state SHALL be START.
REQ-013 In IDLE with rempty high, rinc SHALL stay low and txd SHALL stay 1.
REQ-014 rinc SHALL never be high outside IDLE and never high for two consecutive cycles.
REQ-015 START SHALL drive txd=0 for exactly CLKS_PER_BIT cycles.
REQ-016 DATA SHALL drive DSIZE bits LSB first, CLKS_PER_BIT cycles each, with a bit index counter of width clog2(DSIZE)+1.
REQ-017 STOP SHALL drive txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 The baud counter SHALL be clog2(CLKS_PER_BIT) bits wide, SHALL count 0..CLKS_PER_BIT-1, and SHALL reload to 0 on every state change.
REQ-019 Back-to-back words SHALL be separated by exactly one IDLE cycle (txd=1), so the next start bit begins one cycle after the final stop cycle plus one pop cycle.
REQ-020 txd SHALL be registered and glitch-free; busy SHALL be registered, except for its assertion in the pop cycle.
REQ-021 Changes on rempty or rdata outside IDLE SHALL be ignored.

Reset
REQ-022 Asserting rrst SHALL immediately force the state to IDLE, txd=1, busy=0, rinc=0, and all counters and the shift register to 0.
REQ-023 Asserting rrst mid-frame SHALL abort the frame, and the popped word SHALL be lost with no re-pop.
REQ-024 The first pop after reset deassertion SHALL occur no earlier than the first rclk edge with rrst low.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, a PARITY state SHALL be inserted after DATA and drive the even parity bit (XOR of the latched word) for CLKS_PER_BIT cycles.
REQ-026 Without UART_TX_PARITY_EN, PARITY SHALL be unreachable and DATA SHALL go directly to STOP, with the frame length 1+DSIZE+STOP_BITS bits.

Structure
REQ-027 The shared package fifo_uart_pkg SHALL hold the state encoding constants (3-bit), the default CLKS_PER_BIT, and the idle line level.
REQ-028 The baud counter SHALL be a single sub-module, baud_tick, that outputs a one-cycle tick at count CLKS_PER_BIT-1 and has a synchronous restart input.
REQ-029 The FSM, shift register and bit counter SHALL stay in fifo_uart_tx; there SHALL be no other sub-modules.

Verification (CLKS_PER_BIT=4, DSIZE=8, STOP_BITS=1)
REQ-030 Reset test: assert rrst mid-cycle -> txd=1, rinc=0, busy=0 immediately.
REQ-031 Single word: FIFO holds 0xA5 -> one rinc pulse, then txd sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; busy high 41 cycles.
REQ-032 Back-to-back words: FIFO holds 0x00,0xFF -> rinc pulses 41 cycles apart, one idle-high cycle between frames, second data bits all 1.
REQ-033 Parity: UART_TX_PARITY_EN defined, word 0x07 -> parity bit 1 after data, frame 11 bits (44 cycles); with word 0x03 -> parity bit 0.
REQ-034 Reset mid-DATA: rrst asserted at bit 3 -> txd=1 same cycle, no rinc while rrst is high, and after release the next FIFO word is popped and sent complete.
REQ-035 Empty FIFO: rempty held high 200 cycles -> rinc never asserted, txd constant 1, busy 0.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// default baud divisor and the idle line level.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 868;
    localparam logic IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// A synchronous restart holds the count at zero.
module baud_tick #(
    parameter int CLKS_PER_BIT = fifo_uart_pkg::DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a FIFO read port and serialises them as 8N1-style UART frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DSIZE        = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic             txd,
    output logic             busy
);

    localparam int            IW        = $clog2(DSIZE) + 1;
    localparam logic [IW-1:0] LAST_BIT  = IW'(DSIZE - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    state_t           state;
    logic [DSIZE-1:0] shreg;
    logic [IW-1:0]    bit_idx;
    logic             txd_r;
    logic             busy_r;
    logic             tick;
    logic             restart;
`ifdef UART_TX_PARITY_EN
    logic             par;
`endif

    // Pop is combinational so the word is taken in the same IDLE cycle; held off during reset.
    assign rinc    = (state == IDLE) && !rempty && !rrst;
    assign busy    = busy_r | rinc;
    assign txd     = txd_r;
    assign restart = (state == IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (rclk),
        .rst    (rrst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            txd_r   <= IDLE_LEVEL;
            busy_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    txd_r <= IDLE_LEVEL;
                    if (rinc) begin
                        shreg   <= rdata;
                        bit_idx <= '0;
                        txd_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= START;
`ifdef UART_TX_PARITY_EN
                        par     <= ^rdata;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        txd_r <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            txd_r   <= par;
                            state   <= PARITY;
`else
                            txd_r   <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd_r   <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        txd_r <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // bit_idx is reused to count stop-bit periods.
                    if (tick) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            busy_r  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    txd_r  <= IDLE_LEVEL;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT and every cycle
// is compared against the line waveform expected from the framing rules.
module tb_fifo_uart_tx;

    localparam int DSIZE     = 8;
    localparam int CPB       = 4;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_CYC = (1 + DSIZE + PBITS + STOP_BITS) * CPB;

    typedef struct packed {
        logic txd;
        logic rinc;
        logic busy;
    } obs_t;

    logic             rclk = 1'b0;
    logic             rrst;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             txd;
    logic             busy;

    int tests = 0;
    int fails = 0;

    logic [DSIZE-1:0] fifo_q[$];
    obs_t             exp_q[$];

    always #5 rclk = ~rclk;

    fifo_uart_tx #(
        .DSIZE       (DSIZE),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .rclk  (rclk),
        .rrst  (rrst),
        .rdata (rdata),
        .rempty(rempty),
        .rinc  (rinc),
        .txd   (txd),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outside a valid word the read data is garbage, so keep it changing.
    task automatic drive_fifo();
        rempty = (fifo_q.size() == 0);
        if (rempty) rdata = DSIZE'($urandom);
        else        rdata = fifo_q[0];
    endtask

    task automatic push(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic run_cycle(output obs_t o);
        logic [DSIZE-1:0] dummy;
        #1;
        o.txd  = txd;
        o.rinc = rinc;
        o.busy = busy;
        @(negedge rclk);
        if (o.rinc && fifo_q.size() != 0) dummy = fifo_q.pop_front();
        drive_fifo();
    endtask

    // One pop cycle followed by each frame bit held for CPB cycles.
    task automatic expect_word(input logic [DSIZE-1:0] w);
        int   nb;
        logic b;
        nb = 1 + DSIZE + PBITS + STOP_BITS;
        exp_q.push_back(3'b111);
        for (int k = 0; k < nb; k++) begin
            if (k == 0)                          b = 1'b0;
            else if (k <= DSIZE)                 b = w[k-1];
            else if (PBITS == 1 && k == DSIZE+1) b = ^w;
            else                                 b = 1'b1;
            for (int c = 0; c < CPB; c++) exp_q.push_back({b, 1'b0, 1'b1});
        end
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b100);
    endtask

    task automatic check_exp(input string tag, input int n, output int busy_cnt);
        obs_t o;
        obs_t e;
        int   lim;
        busy_cnt = 0;
        lim = (n < 0) ? exp_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            e = exp_q.pop_front();
            run_cycle(o);
            busy_cnt += int'(o.busy);
            check($sformatf("%s[%0d] {txd,rinc,busy}", tag, i), 32'(o), 32'(e));
        end
    endtask

    initial begin
        obs_t             o;
        int               bc;
        int               bad_rinc, bad_txd, bad_busy;
        logic [DSIZE-1:0] w1, w2;

        rrst = 1'b1;
        drive_fifo();

        // Reset held with a word waiting: nothing may be popped.
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            run_cycle(o);
            check("reset_hold", 32'(o), 32'(3'b100));
        end
        check("reset_no_pop", fifo_q.size(), 1);

        rrst = 1'b0;
        expect_word(8'hA5);
        check_exp("single_a5", -1, bc);
        check("single_busy_cycles", bc, FRAME_CYC + 1);
        expect_idle(3);
        check_exp("single_idle", -1, bc);

        push(8'h00);
        push(8'hFF);
        expect_word(8'h00);
        expect_word(8'hFF);
        expect_idle(2);
        check_exp("b2b", -1, bc);
        check("b2b_busy_cycles", bc, 2 * (FRAME_CYC + 1));
        check("b2b_fifo_drained", fifo_q.size(), 0);

        push(8'h07);
        expect_word(8'h07);
        expect_idle(2);
        check_exp("word_07", -1, bc);
        push(8'h03);
        expect_word(8'h03);
        expect_idle(2);
        check_exp("word_03", -1, bc);

        bad_rinc = 0;
        bad_txd  = 0;
        bad_busy = 0;
        for (int i = 0; i < 200; i++) begin
            run_cycle(o);
            if (o.rinc !== 1'b0) bad_rinc++;
            if (o.txd  !== 1'b1) bad_txd++;
            if (o.busy !== 1'b0) bad_busy++;
        end
        check("empty_rinc_cycles", bad_rinc, 0);
        check("empty_txd_low_cycles", bad_txd, 0);
        check("empty_busy_cycles", bad_busy, 0);

        // Abort during data bit 3, which is forced to 0 so the reset is visible on txd.
        w1 = DSIZE'($urandom) & 8'hF7;
        w2 = DSIZE'($urandom);
        push(w1);
        push(w2);
        expect_word(w1);
        check_exp("abort_pre", 1 + CPB + 3 * CPB, bc);
        check("abort_txd_before", txd, w1[3]);
        exp_q.delete();
        #2 rrst = 1'b1;
        #1 check("abort_now", 32'({txd, rinc, busy}), 32'(3'b100));
        @(negedge rclk);
        for (int i = 0; i < 4; i++) begin
            run_cycle(o);
            check("abort_hold", 32'(o), 32'(3'b100));
        end
        check("abort_word_lost", fifo_q.size(), 1);
        rrst = 1'b0;
        expect_word(w2);
        expect_idle(2);
        check_exp("abort_next", -1, bc);
        check("abort_next_drained", fifo_q.size(), 0);

        for (int it = 0; it < 4; it++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) begin
                logic [DSIZE-1:0] w;
                w = DSIZE'($urandom);
                push(w);
                expect_word(w);
            end
            expect_idle($urandom_range(1, 4));
            check_exp($sformatf("rand%0d", it), -1, bc);
            check($sformatf("rand%0d_busy_cycles", it), bc, nw * (FRAME_CYC + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
